// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared types and default constants for the switch debouncer
package sw_debounce_pkg;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_t;

   localparam int SW_WIDTH         = 16;
   localparam int SW_STABLE_CYCLES = 1000;

endpackage

// File: rtl/sw_debounce_db_bit.sv
// rtl/sw_debounce_db_bit.sv - one switch bit: two-flop synchroniser, hold counter, FSM and edge pulses
module db_bit
   import sw_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = SW_STABLE_CYCLES,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_in,
   output logic sw_db,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             flip;

   always_comb begin
      s1_d    = sw_in;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      flip    = 1'b0;

      case (state_q)
         DB_STABLE: begin
            if (s2_q != db_q) begin
               // a one-cycle hold time needs no counting at all
               if (STABLE_CYCLES == 1) begin
                  flip = 1'b1;
               end else begin
                  state_d = DB_PENDING;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         DB_PENDING: begin
            if (s2_q == db_q) begin
               state_d = DB_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               flip    = 1'b1;
               state_d = DB_STABLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = DB_STABLE;
            cnt_d   = '0;
         end
      endcase

      if (flip) begin
         db_d   = s2_q;
         rise_d = s2_q;
         fall_d = ~s2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= DB_STABLE;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign sw_db = db_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - debounces a vector of raw slide switches into a clean registered vector with edge pulses
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH         = SW_WIDTH,
   parameter int STABLE_CYCLES = SW_STABLE_CYCLES,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      db_bit #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W)
      ) u_bit (
         .clk   (clk),
         .rst   (rst),
         .sw_in (sw[i]),
         .sw_db (sw_db[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );
   end

   assign changed = |(rise | fall);

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed bench for sw_debounce with a cycle-stamped scoreboard of expected flips
module tb_sw_debounce;

   localparam int W  = 16;
   localparam int SC = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] sw  = '0;
   logic [W-1:0] sw_db, rise, fall;
   logic         changed;

   always #5 clk = ~clk;

   sw_debounce #(
      .WIDTH         (W),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw),
      .sw_db   (sw_db),
      .rise    (rise),
      .fall    (fall),
      .changed (changed)
   );

   typedef struct {
      int           at;
      logic [W-1:0] db;
      logic [W-1:0] rs;
      logic [W-1:0] fl;
   } ev_t;

   ev_t          sb[$];
   int           cyc    = 0;
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] exp_db   = '0;
   logic [W-1:0] exp_rise = '0;
   logic [W-1:0] exp_fall = '0;
   logic [W-1:0] sched_db = '0;
   string        phase    = "init";

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s/%s cyc=%0d observed=%h expected=%h", phase, tag, cyc, obs, expv);
      end
   endtask

   task automatic check_all();
      check("sw_db", sw_db, exp_db);
      check("rise", rise, exp_rise);
      check("fall", fall, exp_fall);
      check("changed", {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, |(exp_rise | exp_fall)});
   endtask

   task automatic tick();
      ev_t ev;
      @(posedge clk);
      cyc++;
      #1;
      if (sb.size() > 0 && sb[0].at == cyc) begin
         ev       = sb.pop_front();
         exp_db   = ev.db;
         exp_rise = ev.rs;
         exp_fall = ev.fl;
      end else begin
         exp_rise = '0;
         exp_fall = '0;
      end
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // drive a new switch vector; bits in mask are expected to flip SC+1 edges after capture
   task automatic chg(input logic [W-1:0] new_sw, input logic [W-1:0] mask);
      ev_t ev;
      sw       = new_sw;
      sched_db = (sched_db & ~mask) | (new_sw & mask);
      ev.at    = cyc + 2 + SC;
      ev.db    = sched_db;
      ev.rs    = mask & new_sw;
      ev.fl    = mask & ~new_sw;
      sb.push_back(ev);
   endtask

   task automatic enter_reset();
      rst      = 1'b1;
      sb.delete();
      exp_db   = '0;
      sched_db = '0;
   endtask

   task automatic release_reset(input logic [W-1:0] expect_db);
      ev_t ev;
      rst      = 1'b0;
      sched_db = expect_db;
      ev.at    = cyc + 1 + 1 + SC;
      ev.db    = expect_db;
      ev.rs    = expect_db;
      ev.fl    = '0;
      sb.push_back(ev);
   endtask

   initial begin
      phase = "reset";
      #2;
      sw = 16'hFFFF;
      @(posedge clk);
      @(posedge clk);
      #3;
      enter_reset();
      #1;
      exp_rise = '0;
      exp_fall = '0;
      check_all();
      run(2);
      release_reset(16'hFFFF);
      run(8);

      phase = "fall_all";
      chg(16'h0000, 16'hFFFF);
      run(7);

      phase = "clean_step";
      chg(16'h0001, 16'h0001);
      run(8);

      phase = "bounce";
      sw = 16'h0009; tick();
      sw = 16'h0001; tick();
      sw = 16'h0009; tick();
      sw = 16'h0001; tick();
      chg(16'h0009, 16'h0008);
      run(8);

      phase = "glitch";
      sw = 16'h0029;
      run(3);
      sw = 16'h0009;
      run(8);

      phase = "clear";
      chg(16'h0000, 16'h0009);
      run(7);

      phase = "simultaneous";
      chg(16'h0303, 16'h0303);
      run(7);
      chg(16'h0000, 16'h0303);
      run(7);

      phase = "reset_mid";
      sw = 16'h0002;
      run(2);
      enter_reset();
      #1;
      check_all();
      run(2);
      release_reset(16'h0002);
      run(9);

      phase = "end";
      checks++;
      assert (sb.size() == 0)
      else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
